tempo_controller: RTL and testbench

Tempo-setting stage that sits directly upstream of the metronome sequencer. It debounces the tap-up and tap-down keys, applies switch presets, and holds the current tempo in BPM. It computes the beat period in clock cycles with a sequential divider and converts the BPM to BCD digits for HEX2..HEX0. The metronome consumes `period`, `period_update` and the BCD digits.

---
 rtl/tempo_pkg.sv | 31 +++
 rtl/key_debounce.sv | 44 ++++
 rtl/tempo_controller.sv | 196 +++++++++++++++++++
 tb/tb_tempo_controller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tempo_pkg.sv
// Shared FSM state type, default tempo constants and the divider step record
// used by the tempo controller.
package tempo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_BCD,
        ST_DONE
    } state_t;

    localparam int unsigned CLK_HZ_DEF      = 50_000_000;
    localparam int unsigned BPM_MIN_DEF     = 40;
    localparam int unsigned BPM_MAX_DEF     = 240;
    localparam int unsigned BPM_DEFAULT_DEF = 120;

    function automatic logic [31:0] period_of(input int unsigned clk_hz,
                                              input int unsigned bpm_val);
        logic [63:0] cycles_per_min;
        cycles_per_min = 64'(clk_hz) * 64'd60;
        return 32'(cycles_per_min / 64'(bpm_val));
    endfunction

    localparam logic [31:0] PERIOD_RESET = period_of(CLK_HZ_DEF, BPM_DEFAULT_DEF);

    typedef struct packed {
        logic [7:0]  rem;
        logic [31:0] quo;
    } div_t;

endpackage

// File: rtl/key_debounce.sv
// Active-low key debouncer: 2-FF synchroniser, stable-level counter and a
// single-cycle press pulse; the key must be released stably before re-arming.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          armed;
    logic [CW-1:0] cnt;
    logic          level_ok;

    // Armed: waiting for a stable low. Disarmed: waiting for a stable high.
    assign level_ok = armed ? ~sync2 : sync2;
    assign press    = armed & level_ok & (cnt == LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            armed <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            if (!level_ok) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                armed <= ~armed;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tempo_controller.sv
// Tempo controller: debounced taps and switch presets set the BPM; one FSM
// then derives the beat period (restoring divider) and BCD display digits.
module tempo_controller
    import tempo_pkg::*;
#(
    parameter int unsigned CLK_HZ          = CLK_HZ_DEF,
    parameter int unsigned BPM_MIN         = BPM_MIN_DEF,
    parameter int unsigned BPM_MAX         = BPM_MAX_DEF,
    parameter int unsigned BPM_DEFAULT     = BPM_DEFAULT_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  preset,
    input  logic        tapup_n,
    input  logic        tapdown_n,
    output logic [7:0]  bpm,
    output logic [31:0] period,
    output logic        period_valid,
    output logic        period_update,
    output logic        busy,
    output logic [3:0]  hex100,
    output logic [3:0]  hex10,
    output logic [3:0]  hex0
);
    localparam logic [31:0] DIVIDEND     = 32'(64'(CLK_HZ) * 64'd60);
    localparam logic [31:0] RESET_PERIOD = period_of(CLK_HZ, BPM_DEFAULT);
    localparam logic [7:0]  MIN_B        = 8'(BPM_MIN);
    localparam logic [7:0]  MAX_B        = 8'(BPM_MAX);
    localparam logic [7:0]  DEF_B        = 8'(BPM_DEFAULT);
    localparam logic [3:0]  RST_H        = 4'(BPM_DEFAULT / 100);
    localparam logic [3:0]  RST_T        = 4'((BPM_DEFAULT / 10) % 10);
    localparam logic [3:0]  RST_U        = 4'(BPM_DEFAULT % 10);

    function automatic logic [7:0] sat_tap(input logic [7:0] cur, input logic up);
        if (up) begin
            return (cur >= MAX_B) ? MAX_B : cur + 8'd1;
        end
        return (cur <= MIN_B) ? MIN_B : cur - 8'd1;
    endfunction

    function automatic logic [7:0] sat_preset(input logic [4:0] sw);
        logic [9:0] raw;
        raw = 10'd60 + 10'(sw) * 10'd10;
        if (raw > 10'(BPM_MAX)) return MAX_B;
        if (raw < 10'(BPM_MIN)) return MIN_B;
        return raw[7:0];
    endfunction

    function automatic div_t div_iter(input div_t cur, input logic [7:0] dvs);
        logic [8:0] trial;
        div_t       nxt;
        trial = {cur.rem, cur.quo[31]};
        if (trial >= {1'b0, dvs}) begin
            nxt.rem = 8'(trial - {1'b0, dvs});
            nxt.quo = {cur.quo[30:0], 1'b1};
        end else begin
            nxt.rem = trial[7:0];
            nxt.quo = {cur.quo[30:0], 1'b0};
        end
        return nxt;
    endfunction

    // {hundreds, tens, units, binary}: add 3 to any digit >= 5, then shift.
    function automatic logic [19:0] dabble_step(input logic [19:0] v);
        logic [19:0] t;
        t = v;
        for (int i = 0; i < 3; i++) begin
            if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    logic [4:0]  preset_s1;
    logic [4:0]  preset_s2;
    logic [4:0]  preset_prev;
    logic        up_press;
    logic        dn_press;
    logic        preset_evt;
    logic [7:0]  bpm_new;
    logic        start;
    state_t      state;
    state_t      state_next;
    logic [4:0]  iter;
    logic        div_step;
    logic        bcd_step;
    logic        load_out;
    div_t        div_r;
    logic [19:0] dd;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_tapup (
        .clock (clock),
        .reset (reset),
        .key_n (tapup_n),
        .press (up_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_tapdown (
        .clock (clock),
        .reset (reset),
        .key_n (tapdown_n),
        .press (dn_press)
    );

    // Preset beats taps; opposing taps cancel; unchanged BPM is not an event.
    always_comb begin
        preset_evt = (preset_s2 != preset_prev);
        bpm_new    = bpm;
        if (preset_evt) begin
            bpm_new = sat_preset(preset_s2);
        end else if (up_press && !dn_press) begin
            bpm_new = sat_tap(bpm, 1'b1);
        end else if (dn_press && !up_press) begin
            bpm_new = sat_tap(bpm, 1'b0);
        end
        start = (bpm_new != bpm);
    end

    always_comb begin
        state_next = state;
        div_step   = 1'b0;
        bcd_step   = 1'b0;
        load_out   = 1'b0;
        if (start) begin
            state_next = ST_DIV;
        end else begin
            case (state)
                ST_DIV: begin
                    div_step = 1'b1;
                    if (iter == 5'd31) state_next = ST_BCD;
                end
                ST_BCD: begin
                    bcd_step = 1'b1;
                    if (iter == 5'd7) state_next = ST_DONE;
                end
                ST_DONE: begin
                    load_out   = 1'b1;
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            iter          <= '0;
            preset_s1     <= '0;
            preset_s2     <= '0;
            preset_prev   <= '0;
            bpm           <= DEF_B;
            period        <= RESET_PERIOD;
            hex100        <= RST_H;
            hex10         <= RST_T;
            hex0          <= RST_U;
            period_valid  <= 1'b1;
            period_update <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            preset_s1     <= preset;
            preset_s2     <= preset_s1;
            preset_prev   <= preset_s2;
            period_update <= load_out;
            if (start) begin
                bpm          <= bpm_new;
                busy         <= 1'b1;
                period_valid <= 1'b0;
                iter         <= '0;
            end else if (div_step || bcd_step) begin
                iter <= (state_next != state) ? 5'd0 : iter + 5'd1;
            end
            if (load_out) begin
                period       <= div_r.quo;
                hex100       <= dd[19:16];
                hex10        <= dd[15:12];
                hex0         <= dd[11:8];
                period_valid <= 1'b1;
                busy         <= 1'b0;
            end
        end
    end

    // Working registers; their content only matters between start and DONE.
    always_ff @(posedge clock) begin
        if (start) begin
            div_r <= '{rem: 8'd0, quo: DIVIDEND};
            dd    <= {12'd0, bpm_new};
        end else begin
            if (div_step) div_r <= div_iter(div_r, bpm);
            if (bcd_step) dd <= dabble_step(dd);
        end
    end

endmodule

// File: tb/tb_tempo_controller.sv
// Scoreboard bench for tempo_controller with a short debounce window.
module tb_tempo_controller;

    logic        clock     = 1'b0;
    logic        reset     = 1'b1;
    logic [4:0]  preset    = 5'd0;
    logic        tapup_n   = 1'b1;
    logic        tapdown_n = 1'b1;
    logic [7:0]  bpm;
    logic [31:0] period;
    logic        period_valid;
    logic        period_update;
    logic        busy;
    logic [3:0]  hex100;
    logic [3:0]  hex10;
    logic [3:0]  hex0;

    tempo_controller #(.DEBOUNCE_CYCLES(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .preset        (preset),
        .tapup_n       (tapup_n),
        .tapdown_n     (tapdown_n),
        .bpm           (bpm),
        .period        (period),
        .period_valid  (period_valid),
        .period_update (period_update),
        .busy          (busy),
        .hex100        (hex100),
        .hex10         (hex10),
        .hex0          (hex0)
    );

    always #5 clock = ~clock;

    typedef struct {
        int     bpm;
        longint period;
        int     h;
        int     t;
        int     u;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   change_cyc = 0;
    int   upd_count  = 0;
    int   bpm_seen   = 0;

    task automatic check_eq(input string tag, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic exp_t model(input int b);
        exp_t e;
        e.bpm    = b;
        e.period = (longint'(50_000_000) * 60) / b;
        e.h      = b / 100;
        e.t      = (b / 10) % 10;
        e.u      = b % 10;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin : monitor
        exp_t ex;
        if (int'(bpm) != bpm_seen) begin
            bpm_seen   = int'(bpm);
            change_cyc = cyc;
        end
        if (!reset && period_update) begin
            upd_count++;
            check_eq("update_expected", (sb.size() != 0) ? 1 : 0, 1);
            if (sb.size() != 0) begin
                ex = sb.pop_front();
                check_eq("upd_bpm", bpm, ex.bpm);
                check_eq("upd_period", period, ex.period);
                check_eq("upd_hex100", hex100, ex.h);
                check_eq("upd_hex10", hex10, ex.t);
                check_eq("upd_hex0", hex0, ex.u);
                check_eq("upd_valid", period_valid, 1);
                check_eq("upd_busy", busy, 0);
                check_eq("upd_latency", cyc - change_cyc, 41);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_bpm"}, bpm, 120);
        check_eq({tag, "_period"}, period, 25_000_000);
        check_eq({tag, "_hex100"}, hex100, 1);
        check_eq({tag, "_hex10"}, hex10, 2);
        check_eq({tag, "_hex0"}, hex0, 0);
        check_eq({tag, "_valid"}, period_valid, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_update"}, period_update, 0);
    endtask

    initial begin
        int fall_cyc;
        int base;

        tick(3);
        check_reset_values("reset");
        reset = 1'b0;
        tick(5);

        // Single tap-up, including raw-fall-to-bpm latency.
        sb.push_back(model(121));
        fall_cyc = cyc;
        tapup_n = 1'b0;
        tick(20);
        tapup_n = 1'b1;
        tick(70);
        check_eq("tapup_bpm", bpm, 121);
        check_eq("tapup_key_latency", change_cyc - fall_cyc, 18);
        check_eq("tapup_drained", sb.size(), 0);

        sb.push_back(model(120));
        tapdown_n = 1'b0;
        tick(20);
        tapdown_n = 1'b1;
        tick(70);
        check_eq("tapdown_bpm", bpm, 120);

        // Bouncing key never stays low long enough.
        base = upd_count;
        repeat (10) begin
            tapdown_n = 1'b0;
            tick(8);
            tapdown_n = 1'b1;
            tick(8);
        end
        tick(60);
        check_eq("bounce_bpm", bpm, 120);
        check_eq("bounce_no_update", upd_count, base);

        sb.push_back(model(70));
        preset = 5'd1;
        tick(60);
        check_eq("preset1_bpm", bpm, 70);

        sb.push_back(model(240));
        preset = 5'd20;
        tick(60);
        check_eq("preset20_bpm", bpm, 240);

        base = upd_count;
        tapup_n = 1'b0;
        tick(20);
        tapup_n = 1'b1;
        tick(70);
        check_eq("sat_max_bpm", bpm, 240);
        check_eq("sat_max_no_update", upd_count, base);

        // Preset change and tap-down land on the same edge.
        sb.push_back(model(60));
        tapdown_n = 1'b0;
        tick(15);
        preset = 5'd0;
        tick(5);
        tapdown_n = 1'b1;
        tick(70);
        check_eq("simul_bpm", bpm, 60);

        // Restart 10 cycles into the divider.
        sb.push_back(model(120));
        preset = 5'd1;
        tick(10);
        preset = 5'd6;
        tick(70);
        check_eq("restart_div_bpm", bpm, 120);

        // Second tap-up as early as the debouncer allows (lands in BCD).
        sb.push_back(model(122));
        tapup_n = 1'b0;
        tick(18);
        tapup_n = 1'b1;
        tick(18);
        tapup_n = 1'b0;
        tick(20);
        tapup_n = 1'b1;
        tick(60);
        check_eq("restart_tap_bpm", bpm, 122);

        // Reset while the BCD conversion is running.
        base = upd_count;
        preset = 5'd2;
        tick(38);
        check_eq("bcd_busy", busy, 1);
        check_eq("bcd_bpm", bpm, 80);
        reset  = 1'b1;
        preset = 5'd0;
        tick(1);
        check_reset_values("mid_reset");
        tick(2);
        reset = 1'b0;
        tick(60);
        check_eq("post_reset_bpm", bpm, 120);
        check_eq("post_reset_no_update", upd_count, base);

        check_eq("sb_drained_end", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
